i2s_capture_ctrl: RTL and testbench

I2S_CAPTURE_CTRL -- requirements
Module: i2s_capture_ctrl

---
 rtl/i2s_capture_ctrl.sv | 161 ++++++++++++++++
 tb/tb_i2s_capture_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_capture_ctrl.sv
// ---------------------------------------------------------------------------
// i2s_capture_ctrl
//   Collects samples from an I2S receiver into a ping-pong frame RAM. Each
//   bank holds FRAME_LEN samples. When a bank fills up it is flagged ready for
//   the consumer and capture moves on to the other bank. If the other bank has
//   not been consumed yet, capture stalls and counts the dropped samples. It
//   then re-aligns to a left sample once that bank is freed.
//
// Ports
//   clk, rst_n              system clock, asynchronous active-low reset
//   enable                  capture enable (level); low discards the partial frame
//   chan_mode               00 left, 01 right, 10 mono average, 11 same as 00
//   left_data/right_data    signed samples from the receiver
//   left_valid/right_valid  single-cycle sample strobes
//   wr_en/wr_bank/wr_addr/wr_data   registered frame RAM write port
//   frame_ready/frame_bank  a full frame is waiting / oldest unconsumed bank
//   frame_ack               consumer is done with the bank on frame_bank
//   overrun_cnt             saturating count of samples dropped while stalled
// ---------------------------------------------------------------------------
module i2s_capture_ctrl #(
  parameter int DATA_BITS = 24,
  parameter int FRAME_LEN = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           chan_mode,
  input  logic [DATA_BITS-1:0] left_data,
  input  logic [DATA_BITS-1:0] right_data,
  input  logic                 left_valid,
  input  logic                 right_valid,
  output logic                 wr_en,
  output logic                 wr_bank,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 frame_ready,
  output logic                 frame_bank,
  input  logic                 frame_ack,
  output logic [15:0]          overrun_cnt
);

  typedef enum logic [1:0] {IDLE, ALIGN, CAPTURE, STALL} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   ptr_q;        // next address to write in the fill bank
  logic                   bank_q;       // bank currently being filled
  logic [1:0]             ready_q;      // per-bank "full, not yet consumed"
  logic                   rd_q;         // oldest ready bank (consumer side)
  logic [DATA_BITS-1:0]   left_q;       // left sample held for mono averaging

  logic [1:0]             mode_eff;
  logic                   qual;
  logic                   cap_path;
  logic                   do_write;
  logic                   do_drop;
  logic                   frame_done;
  logic                   ack_ok;
  logic [1:0]             ready_ack;
  logic [1:0]             ready_d;
  logic [DATA_BITS-1:0]   left_eff;
  logic signed [DATA_BITS:0] sum_ext;
  logic [DATA_BITS-1:0]   sample;

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    mode_eff   = (chan_mode == 2'b11) ? 2'b00 : chan_mode;

    // Same-cycle left and right: left is taken first, so the average already
    // sees the new left value.
    left_eff   = left_valid ? left_data : left_q;
    sum_ext    = $signed({left_eff[DATA_BITS-1], left_eff})
               + $signed({right_data[DATA_BITS-1], right_data});

    sample     = left_data;
    qual       = left_valid;
    unique case (mode_eff)
      2'b01: begin
        sample = right_data;
        qual   = right_valid;
      end
      2'b10: begin
        sample = DATA_BITS'(sum_ext >>> 1);
        qual   = right_valid;
      end
      default: begin
        sample = left_data;
        qual   = left_valid;
      end
    endcase

    // The left strobe that ends ALIGN also belongs to the new frame.
    cap_path   = (state_q == CAPTURE) || (state_q == ALIGN && left_valid);
    do_write   = enable && cap_path && qual;
    do_drop    = enable && (state_q == STALL) && qual;
    frame_done = do_write && (ptr_q == ADDR_BITS'(FRAME_LEN - 1));

    // The consumer ack is applied before a frame completion in the same cycle,
    // so a completion racing an ack on the other bank does not stall.
    ack_ok     = frame_ack && (ready_q != 2'b00);
    ready_ack  = ready_q;
    if (ack_ok) ready_ack[rd_q] = 1'b0;
    ready_d    = ready_ack;
    if (frame_done) ready_d[bank_q] = 1'b1;

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = ALIGN;
      ALIGN:   if (left_valid) state_d = CAPTURE;
      CAPTURE: if (frame_done && ready_ack[~bank_q]) state_d = STALL;
      STALL:   if (!ready_ack[bank_q]) state_d = ALIGN;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  assign frame_ready = |ready_q;
  assign frame_bank  = rd_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      bank_q      <= 1'b0;
      ready_q     <= 2'b00;
      rd_q        <= 1'b0;
      left_q      <= '0;
      overrun_cnt <= '0;
      wr_en       <= 1'b0;
      wr_bank     <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      wr_en   <= do_write;

      if (ack_ok) rd_q <= ~rd_q;

      if (left_valid && mode_eff == 2'b10) left_q <= left_data;

      if (do_drop && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;

      if (!enable) begin
        ptr_q   <= '0;
        wr_addr <= '0;
      end else if (do_write) begin
        wr_bank <= bank_q;
        wr_addr <= ptr_q;
        wr_data <= sample;
        // FRAME_LEN is a power of two, so the pointer wraps to 0 by itself.
        ptr_q   <= ptr_q + ADDR_BITS'(1);
        if (frame_done) bank_q <= ~bank_q;
      end
    end
  end

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2s_capture_ctrl
//   Self-checking bench for i2s_capture_ctrl (FRAME_LEN=8, DATA_BITS=24).
//   A behavioural model tracks the frame fill count and a FIFO of completed
//   banks, and predicts every output after each clock. Directed scenarios cover
//   the documented corner cases, and a randomized run follows them.
// ---------------------------------------------------------------------------
module tb_i2s_capture_ctrl;

  localparam int DW = 24;
  localparam int FL = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    chan_mode = 2'b00;
  logic [DW-1:0] left_data = '0;
  logic [DW-1:0] right_data = '0;
  logic          left_valid = 1'b0;
  logic          right_valid = 1'b0;
  logic          frame_ack = 1'b0;
  logic          wr_en, wr_bank, frame_ready, frame_bank;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [15:0]   overrun_cnt;

  i2s_capture_ctrl #(.DATA_BITS(DW), .FRAME_LEN(FL), .ADDR_BITS(AW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .chan_mode(chan_mode),
    .left_data(left_data), .right_data(right_data),
    .left_valid(left_valid), .right_valid(right_valid),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_ready(frame_ready), .frame_bank(frame_bank),
    .frame_ack(frame_ack), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_armed, m_synced, m_stalled, m_wbank, m_rd;
  int          m_fill, m_ovr;
  bit          m_q[$];          // completed, unconsumed banks, oldest first
  logic [DW-1:0] m_left;
  bit          e_wen, e_bank;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  function automatic bit in_q(input bit b);
    foreach (m_q[i]) if (m_q[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_synced = 0; m_stalled = 0; m_wbank = 0; m_rd = 0;
    m_fill = 0; m_ovr = 0; m_q.delete(); m_left = '0;
    e_wen = 0; e_bank = 0; e_addr = '0; e_data = '0;
  endtask

  task automatic model_step(input bit lv, input bit rv, input logic [DW-1:0] ld,
                            input logic [DW-1:0] rd, input bit ack);
    int md, l, r, a;
    bit qual;
    logic [DW-1:0] smp;
    md = (chan_mode == 2'b11) ? 0 : int'(chan_mode);
    e_wen = 0;
    if (ack && m_q.size() > 0) begin
      void'(m_q.pop_front());
      m_rd = ~m_rd;
    end
    if (md == 2 && lv) m_left = ld;
    qual = (md == 0) ? lv : rv;
    if (md == 0) smp = ld;
    else if (md == 1) smp = rd;
    else begin
      l = $signed(m_left);
      r = $signed(rd);
      a = (l + r) >>> 1;
      smp = a[DW-1:0];
    end
    if (!enable) begin
      m_armed = 0; m_synced = 0; m_stalled = 0; m_fill = 0; e_addr = '0;
    end else if (!m_armed) begin
      m_armed = 1;
    end else if (m_stalled) begin
      if (qual && m_ovr < 65535) m_ovr++;
      if (!in_q(m_wbank)) begin
        m_stalled = 0;
        m_synced = 0;
      end
    end else begin
      if (lv) m_synced = 1;
      if (m_synced && qual) begin
        e_wen = 1; e_bank = m_wbank; e_addr = AW'(m_fill); e_data = smp;
        m_fill++;
        if (m_fill == FL) begin
          m_fill = 0;
          m_q.push_back(m_wbank);
          m_wbank = ~m_wbank;
          if (in_q(m_wbank)) m_stalled = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("wr_en", 32'(wr_en), 32'(e_wen));
    check("wr_bank", 32'(wr_bank), 32'(e_bank));
    check("wr_addr", 32'(wr_addr), 32'(e_addr));
    check("wr_data", 32'(wr_data), 32'(e_data));
    check("frame_ready", 32'(frame_ready), 32'(m_q.size() != 0));
    check("frame_bank", 32'(frame_bank), 32'(m_rd));
    check("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit lv, input bit rv, input logic [DW-1:0] ld,
                      input logic [DW-1:0] rd, input bit ack);
    @(negedge clk);
    left_valid = lv; right_valid = rv; left_data = ld; right_data = rd; frame_ack = ack;
    model_step(lv, rv, ld, rd, ack);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0);
  endtask

  // Reset asserted in the middle of a cycle; outputs must clear right away.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    left_valid = 0; right_valid = 0; frame_ack = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic          o_len, o_lbank, o_ren;
  logic [AW-1:0] o_laddr;
  logic [DW-1:0] o_ldata, o_rdata;

  // One stereo sample pair: left strobe, gap, right strobe, gap.
  task automatic stereo(input logic [DW-1:0] ld, input logic [DW-1:0] rd, input bit ack);
    step(1, 0, ld, '0, ack);
    o_len = wr_en; o_lbank = wr_bank; o_laddr = wr_addr; o_ldata = wr_data;
    idle();
    step(0, 1, '0, rd, 0);
    o_ren = wr_en; o_rdata = wr_data;
    idle();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Mode 00: one bank filled with 1..8, then the 9th sample opens bank 1.
    enable = 1; chan_mode = 2'b00;
    idle();
    for (int i = 1; i <= FL; i++) begin
      stereo(DW'(i), DW'(100 + i), 0);
      check("m00_wen", 32'(o_len), 32'd1);
      check("m00_addr", 32'(o_laddr), 32'(i - 1));
      check("m00_bank", 32'(o_lbank), 32'd0);
      check("m00_data", 32'(o_ldata), 32'(i));
      check("m00_right_ignored", 32'(o_ren), 32'd0);
    end
    check("m00_ready", 32'(frame_ready), 32'd1);
    check("m00_fbank", 32'(frame_bank), 32'd0);
    stereo(DW'(9), DW'(0), 0);
    check("m00_9th_bank", 32'(o_lbank), 32'd1);
    check("m00_9th_addr", 32'(o_laddr), 32'd0);

    // Mono average, including a negative right sample.
    do_reset();
    enable = 1; chan_mode = 2'b10;
    idle();
    stereo(24'h000010, 24'hFFFFF0, 0);
    check("mono_left_nowrite", 32'(o_len), 32'd0);
    check("mono_wen", 32'(o_ren), 32'd1);
    check("mono_zero", 32'(o_rdata), 32'd0);
    stereo(24'd3, 24'd4, 0);
    check("mono_three", 32'(o_rdata), 32'd3);

    // Both banks full, 5 dropped samples, then an ack releases bank 0.
    do_reset();
    enable = 1; chan_mode = 2'b00;
    idle();
    for (int i = 0; i < 2 * FL; i++) stereo(DW'(i), '0, 0);
    for (int i = 0; i < 5; i++) begin
      stereo(24'hABCDEF, '0, 0);
      check("stall_nowrite", 32'(o_len), 32'd0);
    end
    check("stall_overrun", 32'(overrun_cnt), 32'd5);
    step(0, 0, '0, '0, 1);
    check("stall_ack_fbank", 32'(frame_bank), 32'd1);
    stereo(24'h000077, '0, 0);
    check("resume_bank", 32'(o_lbank), 32'd0);
    check("resume_addr", 32'(o_laddr), 32'd0);
    check("resume_data", 32'(o_ldata), 32'h77);

    // Ack arriving in the same cycle bank 1 completes: no stall.
    do_reset();
    enable = 1; chan_mode = 2'b00;
    idle();
    for (int i = 0; i < 2 * FL - 1; i++) stereo(DW'(i), '0, 0);
    stereo(24'h000042, '0, 1);
    check("race_ready", 32'(frame_ready), 32'd1);
    check("race_fbank", 32'(frame_bank), 32'd1);
    stereo(24'h000043, '0, 0);
    check("race_wen", 32'(o_len), 32'd1);
    check("race_bank", 32'(o_lbank), 32'd0);
    check("race_addr", 32'(o_laddr), 32'd0);
    check("race_overrun", 32'(overrun_cnt), 32'd0);

    // A right strobe before any left is ignored; capture starts at the left.
    do_reset();
    enable = 1; chan_mode = 2'b00;
    idle();
    step(0, 1, '0, 24'h000099, 0);
    check("align_right_nowrite", 32'(wr_en), 32'd0);
    stereo(24'h000055, '0, 0);
    check("align_addr", 32'(o_laddr), 32'd0);
    check("align_data", 32'(o_ldata), 32'h55);

    // Disable mid-frame discards the partial frame.
    stereo(24'h1, '0, 0);
    stereo(24'h2, '0, 0);
    enable = 0;
    idle();
    check("disable_addr", 32'(wr_addr), 32'd0);
    enable = 1;
    idle();
    stereo(24'h3, '0, 0);
    check("reenable_addr", 32'(o_laddr), 32'd0);

    // Reset in the middle of a frame.
    do_reset();
    enable = 1;
    idle();
    for (int i = 0; i < 5; i++) stereo(DW'(i + 1), '0, 0);
    do_reset();
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    idle();
    stereo(24'h000123, '0, 0);
    check("post_rst_bank", 32'(o_lbank), 32'd0);
    check("post_rst_addr", 32'(o_laddr), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    enable = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) chan_mode = 2'($urandom_range(0, 3));
      step(($urandom % 4) == 0, ($urandom % 4) == 0, DW'($urandom), DW'($urandom),
           ($urandom % 20) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
